// File: rtl/metav_fifo_pkg.sv
// Shared FIFO helpers: pointer width, occupancy encodings and the
// level-derived state summary used by the FIFO stages.
package metav_fifo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_e;

  localparam int LVL_EMPTY = 0;

  function automatic int ptr_w(input int y);
    return y + 1;
  endfunction

  function automatic int LVL_FULL(input int y);
    return 1 << y;
  endfunction

endpackage

// File: rtl/ansi_in_fifo_if.sv
// Producer/consumer bundle for the FIFO in front of the ansi stage.
interface ansi_in_fifo_if
  import metav_fifo_pkg::*;
#(
  parameter int X = 5,
  parameter int Y = X - 2
);

  logic                  flush;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [X-1:0]          wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [X-1:0]          d_in;
  logic [ptr_w(Y)-1:0]   level;

  modport master (
    output flush, wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, d_in, level
  );

  modport slave (
    input  flush, wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, d_in, level
  );

endinterface

// File: rtl/ansi_in_fifo_mem.sv
// D x X storage array: one synchronous write port, one combinational read
// port. Kept separate so it can later be swapped for an inferred RAM.
module ansi_in_fifo_mem #(
  parameter int X = 5,
  parameter int Y = X - 2
) (
  input  logic         clk,
  input  logic         we,
  input  logic [Y-1:0] waddr,
  input  logic [X-1:0] wdata,
  input  logic [Y-1:0] raddr,
  output logic [X-1:0] rdata
);

  logic [X-1:0] mem [2**Y];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ansi_in_fifo.sv
// First-word-fall-through FIFO feeding ansi.d_in; pointers carry an extra
// wrap bit so full and empty are distinguished without a separate counter.
module ansi_in_fifo
  import metav_fifo_pkg::*;
#(
  parameter int X = 5,
  parameter int Y = X - 2
) (
  input  logic              clk,
  input  logic              rst,
  ansi_in_fifo_if.slave     bus
);

  localparam int            PW    = ptr_w(Y);
  localparam logic [PW-1:0] LVL_E = PW'(LVL_EMPTY);
  localparam logic [PW-1:0] LVL_F = PW'(LVL_FULL(Y));

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] level;
  logic [X-1:0]  rdata;
  fifo_state_e   state;
  logic          can_wr;
  logic          can_rd;
  logic          push;
  logic          pop;
  logic          clear;

  assign level = wr_ptr - rd_ptr;

  always_comb begin
    state = ST_PARTIAL;
    if (level == LVL_E) begin
      state = ST_EMPTY;
    end else if (level == LVL_F) begin
      state = ST_FULL;
    end
  end

  // Handshake flags depend only on registered pointers, never on the
  // opposite side's request, so wr_ready stays independent of rd_ready.
  assign can_wr = (state != ST_FULL);
  assign can_rd = (state != ST_EMPTY);
  assign clear  = rst || bus.flush;
  assign push   = bus.wr_valid && can_wr && !clear;
  assign pop    = bus.rd_ready && can_rd && !clear;

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  ansi_in_fifo_mem #(
    .X (X),
    .Y (Y)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[Y-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr[Y-1:0]),
    .rdata (rdata)
  );

  assign bus.wr_ready = can_wr;
  assign bus.rd_valid = can_rd;
  assign bus.d_in     = can_rd ? rdata : '0;
  assign bus.level    = level;

endmodule

// File: doc/ansi_in_fifo.md
# ansi_in_fifo

Synchronous first-word-fall-through FIFO that sits directly upstream of the `ansi` stage. It buffers `X`-bit words from a valid/ready producer and presents them on `d_in`/`rd_valid` for the consuming stage. It is parameterised with the same `X`/`Y` pair used at the `ansi` instantiation, so one parameter set configures both stages.

## Interface
Parameters:
- `X`, 5, data word width in bits (matches `ansi` `X`)
- `Y`, `X-2`, log2 of FIFO depth; depth `D = 2**Y` (default 8 entries)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous clear; same effect as `rst`, but reset has priority
- `wr_valid`  in  1  producer has a word
- `wr_ready`  out  1  FIFO can accept; `= !full`
- `wr_data`  in  `X`  producer word
- `rd_valid`  out  1  `d_in` holds a valid word; `= !empty`
- `rd_ready`  in  1  consumer takes the word this cycle
- `d_in`  out  `X`  head word, fed to `ansi.d_in`; 0 when `!rd_valid`
- `level`  out  `Y+1`  occupancy, 0..`D`

## Operation
- Storage: `D` x `X` register array, not reset.
- Pointers: `wr_ptr` and `rd_ptr`, each `Y+1` bits.
  - Index = low `Y` bits; the MSB is the wrap bit.
  - Both increment modulo `2**(Y+1)`.
- Conditions: `empty = (wr_ptr == rd_ptr)`; `full = (index equal && wrap bits differ)`; `level = wr_ptr - rd_ptr`, truncated to `Y+1` bits.
- Push when `wr_valid && wr_ready`: write `wr_data` to `mem[wr_ptr index]`, increment `wr_ptr`.
- Pop when `rd_valid && rd_ready`: increment `rd_ptr`.
- Push and pop in the same cycle: both pointers advance and `level` is unchanged. Only possible when not empty and not full.
- Full: `wr_ready=0`; `wr_valid` is ignored and `wr_data` is not written. Not an error.
- Empty: `rd_valid=0` and `d_in=0`; `rd_ready` is ignored.
- Fall-through: `d_in = rd_valid ? mem[rd_ptr index] : 0`, combinational from registered state.
- `rst` or `flush`: pointers go to 0 and memory contents are abandoned.
- State summary, derived from `level`: EMPTY (0), PARTIAL (1..`D-1`), FULL (`D`). No separate FSM register.

## Timing
- Reset values, one cycle after `rst` is sampled high: `wr_ready=1`, `rd_valid=0`, `d_in=0`, `level=0`.
  - `rst` asserted mid-stream discards all words at that edge.
  - A push or pop coinciding with `rst` or `flush` is dropped.
- Write-to-read latency is 1 cycle: a word pushed at edge N is visible on `d_in` with `rd_valid=1` after edge N.
- All outputs are combinational from registers. There is no input-to-output combinational path; in particular, `wr_ready` does not depend on `rd_ready`.
- Full with a simultaneous pop: the write is still refused that cycle (`wr_ready` was 0). `wr_ready` rises after the edge.
- Sustained throughput is 1 word/cycle whenever `0 < level < D`.
- Pointer wrap: after `2**(Y+1)` pushes, `wr_ptr` returns to 0 with no disturbance to `full`, `empty` or `level`.

## Structure
- Shared package `metav_fifo_pkg` holds:
  - the pointer width (`Y+1`) helper function
  - the `level` encoding constants `LVL_EMPTY` and `LVL_FULL(Y)`

  These are reused by other FIFO stages.
- One sub-module is natural: `ansi_in_fifo_mem`.
  - Register array: write port only (`we`, `waddr`, `wdata`), combinational read (`raddr`, `rdata`).
  - Allows a later swap to an inferred RAM.
- Top level holds the pointers, flags, output masking and flush/reset logic.

## Test plan
- Reset then idle: after `rst`, `wr_ready=1`, `rd_valid=0`, `d_in=0`, `level=0`; asserting `rd_ready` changes nothing.
- Fill to full (`X=5`, `Y=3`): push 0x01..0x08 with `rd_ready=0`.
  - `level` goes 1..8, and `wr_ready=0` once 8 words are held.
  - A 9th push of 0x1F is refused; popping all 8 then yields 0x01..0x08 in order.
- Single-word latency: push 0x15 at edge N → `rd_valid=1`, `d_in=0x15` after N; pop at N+1 → `rd_valid=0`, `d_in=0`.
- Simultaneous push/pop at `level=4` for 20 cycles → `level` stays 4, pointers wrap past 15 → 0, and the output order is preserved.
- Full plus pop: at `level=8`, assert `wr_valid` with 0x0A and `rd_ready` together.
  - The pop occurs and the write is refused, giving `level=7`.
  - Next cycle 0x0A is accepted, giving `level=8`.
- Mid-stream `rst` and `flush`: with `level=5`, assert `flush` together with a push → `level=0` and the push is dropped. Repeat with `rst` and get the same result.
